// File: rtl/nios_system2_debug_pkg.sv
// Shared definitions for the processor1 debug on-chip memory: FSM states,
// RAM geometry, JTAG data field positions and the CPU read-only region base.
package nios_system2_debug_pkg;

  localparam int unsigned RAM_DEPTH = 256;
  localparam int unsigned ADDR_W    = $clog2(RAM_DEPTH);
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned JDO_W     = 38;

  localparam int unsigned JDO_LOAD_BIT = 35;
  localparam int unsigned JDO_READ_BIT = 34;
  localparam int unsigned JDO_ADDR_MSB = 33;
  localparam int unsigned JDO_ADDR_LSB = 26;
  localparam int unsigned JDO_DATA_MSB = 34;
  localparam int unsigned JDO_DATA_LSB = 3;

  localparam logic [ADDR_W-1:0] ROM_BASE = ADDR_W'(8'hC0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR
  } ocimem_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ram_req_t;

  function automatic logic in_rom(input logic [ADDR_W-1:0] addr);
    return addr >= ROM_BASE;
  endfunction

endpackage

// File: rtl/nios_system2_processor1_cpu_debug_ram.sv
// 256x32 single-port synchronous RAM, read-before-write, one cycle read latency.
module nios_system2_processor1_cpu_debug_ram
  import nios_system2_debug_pkg::*;
(
  input  logic              clk,
  input  ram_req_t          req,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (req.we) mem[req.addr] <= req.wdata;
    rdata <= mem[req.addr];
  end

endmodule

// File: rtl/nios_system2_processor1_cpu_debug_ocimem.sv
// Debug on-chip memory: JTAG monitor access (MonAReg/MonDReg) and CPU slave
// port sharing one RAM. Optional macro OCIMEM_ROM_PROTECT_EN makes 0xC0-0xFF
// read-only from the CPU port.
module nios_system2_processor1_cpu_debug_ocimem
  import nios_system2_debug_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_waitrequest
);

  ocimem_state_e     state, state_n;
  logic [ADDR_W-1:0] mon_a_reg, mon_a_n;
  logic [DATA_W-1:0] mon_d_n;
  logic              ready_n, error_n;
  logic              cpu_rd_done, cpu_rd_done_n;
  logic              cpu_wr_grant;
  logic              cpu_wr_allowed;
  logic              any_strobe, multi_strobe;
  ram_req_t          ram_req, ram_req_c;
  logic [DATA_W-1:0] ram_rdata;

  logic              jdo_load, jdo_read;
  logic [ADDR_W-1:0] jdo_addr;
  logic [DATA_W-1:0] jdo_data;
  logic              unused_jdo_bits;

  assign jdo_load        = jdo[JDO_LOAD_BIT];
  assign jdo_read        = jdo[JDO_READ_BIT];
  assign jdo_addr        = jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];
  assign jdo_data        = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
  assign unused_jdo_bits = ^{jdo[JDO_W-1:JDO_LOAD_BIT+1], jdo[JDO_DATA_LSB-1:0]};

  assign any_strobe   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign multi_strobe = (take_action_ocimem_a & take_no_action_ocimem_a) |
                        (take_action_ocimem_a & take_action_ocimem_b) |
                        (take_no_action_ocimem_a & take_action_ocimem_b);

`ifdef OCIMEM_ROM_PROTECT_EN
  assign cpu_wr_allowed = ~in_rom(cpu_address);
`else
  assign cpu_wr_allowed = 1'b1;
`endif

  // Next-state, register updates and RAM port arbitration (JTAG over CPU)
  always_comb begin
    state_n       = state;
    mon_a_n       = mon_a_reg;
    mon_d_n       = MonDReg;
    ready_n       = monitor_ready;
    error_n       = monitor_error;
    cpu_rd_done_n = 1'b0;
    cpu_wr_grant  = 1'b0;
    ram_req_c     = '0;

    if (any_strobe) ready_n = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (take_action_ocimem_b) begin
          mon_d_n = jdo_data;
          state_n = ST_WR;
        end else if (take_action_ocimem_a) begin
          if (jdo_load) begin
            mon_a_n = jdo_addr;
            error_n = 1'b0;
          end
          if (jdo_read) begin
            ram_req_c.addr = jdo_load ? jdo_addr : mon_a_reg;
            state_n        = ST_RD_ADDR;
          end
        end else if (take_no_action_ocimem_a) begin
          ram_req_c.addr = mon_a_reg;
          state_n        = ST_RD_ADDR;
        end else if (cpu_read && !cpu_rd_done) begin
          ram_req_c.addr = cpu_address;
          cpu_rd_done_n  = 1'b1;
        end else if (cpu_write) begin
          ram_req_c.addr  = cpu_address;
          ram_req_c.wdata = cpu_writedata;
          ram_req_c.we    = cpu_wr_allowed;
          cpu_wr_grant    = 1'b1;
        end
      end
      ST_RD_ADDR: begin
        mon_d_n = ram_rdata;
        mon_a_n = mon_a_reg + ADDR_W'(1);
        ready_n = 1'b1;
        state_n = ST_RD_DATA;
        if (any_strobe) error_n = 1'b1;
      end
      ST_RD_DATA: begin
        state_n = ST_IDLE;
        if (any_strobe) error_n = 1'b1;
      end
      ST_WR: begin
        ram_req_c.addr  = mon_a_reg;
        ram_req_c.wdata = MonDReg;
        ram_req_c.we    = 1'b1;
        mon_a_n         = mon_a_reg + ADDR_W'(1);
        ready_n         = 1'b1;
        state_n         = ST_IDLE;
        if (any_strobe) error_n = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase

    if (multi_strobe) error_n = 1'b1;
  end

  // A cycle with reset high never writes the RAM
  always_comb begin
    ram_req    = ram_req_c;
    ram_req.we = ram_req_c.we & ~reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      mon_a_reg     <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      cpu_rd_done   <= 1'b0;
    end else begin
      state         <= state_n;
      mon_a_reg     <= mon_a_n;
      MonDReg       <= mon_d_n;
      monitor_ready <= ready_n;
      monitor_error <= error_n;
      cpu_rd_done   <= cpu_rd_done_n;
    end
  end

  // CPU read data is the RAM output in the completion cycle only
  assign cpu_readdata    = cpu_rd_done ? ram_rdata : '0;
  assign cpu_waitrequest = ~reset & ((cpu_read & ~cpu_rd_done) | (cpu_write & ~cpu_wr_grant));

  nios_system2_processor1_cpu_debug_ram u_ram (
    .clk   (clk),
    .req   (ram_req),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_nios_system2_processor1_cpu_debug_ocimem.sv
// Directed bench for the debug on-chip memory: JTAG read/write timing, address
// wrap, strobe errors, CPU arbitration, optional ROM protection and reset abort.
module tb_nios_system2_processor1_cpu_debug_ocimem;
  import nios_system2_debug_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;
  logic [7:0]  cpu_address;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_writedata, cpu_readdata;
  logic        cpu_waitrequest;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  nios_system2_processor1_cpu_debug_ocimem dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_write               (cpu_write),
    .cpu_writedata           (cpu_writedata),
    .cpu_readdata            (cpu_readdata),
    .cpu_waitrequest         (cpu_waitrequest)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_a(input logic load, input logic rd, input logic [7:0] addr);
    jdo = '0;
    jdo[35] = load;
    jdo[34] = rd;
    jdo[33:26] = addr;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic strobe_b(input logic [31:0] d);
    jdo = '0;
    jdo[34:3] = d;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic strobe_na();
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
  endtask

  // Write at current address and return to IDLE
  task automatic jtag_write(input logic [31:0] d);
    strobe_b(d);
    tick();
  endtask

  // Load address, read it, and return to IDLE
  task automatic jtag_read_at(input logic [7:0] addr, output logic [31:0] d);
    strobe_a(1'b1, 1'b1, addr);
    tick();
    d = MonDReg;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          cnt;

    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    cpu_address = '0;
    cpu_read = 1'b1;
    cpu_write = 1'b0;
    cpu_writedata = '0;
    tick();
    tick();
    check_eq("rst_mondreg", MonDReg, 32'h0);
    check_eq("rst_ready", 32'(monitor_ready), 32'h0);
    check_eq("rst_error", 32'(monitor_error), 32'h0);
    check_eq("rst_cpu_rdata", cpu_readdata, 32'h0);
    check_eq("rst_waitreq", 32'(cpu_waitrequest), 32'h0);
    cpu_read = 1'b0;
    reset = 1'b0;
    tick();

    // Preload RAM through JTAG writes
    strobe_a(1'b1, 1'b0, 8'h00);
    jtag_write(32'h0000A5A5);
    check_eq("wr_ready", 32'(monitor_ready), 32'h1);
    check_eq("wr_mondreg", MonDReg, 32'h0000A5A5);
    strobe_a(1'b1, 1'b0, 8'h10);
    strobe_b(32'hDEADBEEF);
    check_eq("wr_ready_clr", 32'(monitor_ready), 32'h0);
    check_eq("wr_mondreg_n1", MonDReg, 32'hDEADBEEF);
    tick();
    check_eq("wr_ready_n2", 32'(monitor_ready), 32'h1);
    jtag_write(32'h11111111);
    strobe_a(1'b1, 1'b0, 8'h20);
    jtag_write(32'h20202020);
    strobe_a(1'b1, 1'b0, 8'hC4);
    jtag_write(32'h0C0C0C0C);
    strobe_a(1'b1, 1'b0, 8'h40);
    jtag_write(32'h44444444);
    jtag_write(32'h45454545);

    // Load + read at 0x10, then sequential read proves MonAReg = 0x11
    strobe_a(1'b1, 1'b1, 8'h10);
    check_eq("rd_ready_clr", 32'(monitor_ready), 32'h0);
    tick();
    check_eq("rd_data", MonDReg, 32'hDEADBEEF);
    check_eq("rd_ready", 32'(monitor_ready), 32'h1);
    tick();
    strobe_na();
    tick();
    check_eq("rd_autoinc", MonDReg, 32'h11111111);
    tick();

    // Write at 0xFF wraps MonAReg to 0x00
    strobe_a(1'b1, 1'b0, 8'hFF);
    strobe_b(32'h12345678);
    tick();
    check_eq("wrap_ready", 32'(monitor_ready), 32'h1);
    strobe_na();
    tick();
    check_eq("wrap_addr0", MonDReg, 32'h0000A5A5);
    tick();
    jtag_read_at(8'hFF, rd);
    check_eq("wr_ff_data", rd, 32'h12345678);

    // Strobe while busy is ignored and flags an error until next address load
    strobe_a(1'b1, 1'b1, 8'h10);
    strobe_na();
    check_eq("busy_err", 32'(monitor_error), 32'h1);
    check_eq("busy_data", MonDReg, 32'hDEADBEEF);
    check_eq("busy_ready", 32'(monitor_ready), 32'h1);
    tick();
    strobe_na();
    tick();
    check_eq("busy_no_read", MonDReg, 32'h11111111);
    tick();
    check_eq("err_sticky", 32'(monitor_error), 32'h1);
    strobe_a(1'b1, 1'b0, 8'h00);
    check_eq("err_clr", 32'(monitor_error), 32'h0);

    // a and b together: b wins, error set
    jdo = '0;
    jdo[34:3] = 32'h2BADF00D;
    take_action_ocimem_a = 1'b1;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    check_eq("multi_b_wins", MonDReg, 32'h2BADF00D);
    tick();
    check_eq("multi_err", 32'(monitor_error), 32'h1);
    jtag_read_at(8'h00, rd);
    check_eq("multi_b_ram", rd, 32'h2BADF00D);
    check_eq("multi_err_clr", 32'(monitor_error), 32'h0);

    // CPU read collides with JTAG read: JTAG first, CPU granted in the next IDLE
    cpu_address = 8'h20;
    cpu_read = 1'b1;
    jdo = '0;
    jdo[35] = 1'b1;
    jdo[34] = 1'b1;
    jdo[33:26] = 8'h10;
    take_action_ocimem_a = 1'b1;
    #1;
    check_eq("cpu_wait_strobe", 32'(cpu_waitrequest), 32'h1);
    tick();
    take_action_ocimem_a = 1'b0;
    check_eq("cpu_wait_busy", 32'(cpu_waitrequest), 32'h1);
    cnt = 0;
    while (cpu_waitrequest && cnt < 10) begin
      tick();
      cnt++;
    end
    check_eq("cpu_rd_timeout", 32'(cpu_waitrequest), 32'h0);
    check_eq("cpu_grant_lat", 32'(cnt), 32'd3);
    check_eq("cpu_rdata", cpu_readdata, 32'h20202020);
    check_eq("cpu_jtag_first", MonDReg, 32'hDEADBEEF);
    cpu_read = 1'b0;
    tick();

    // CPU writes: protected region and plain region
    cpu_address = 8'hC4;
    cpu_writedata = 32'hAAAA5555;
    cpu_write = 1'b1;
    #1;
    check_eq("cpu_wr_accept", 32'(cpu_waitrequest), 32'h0);
    tick();
    cpu_write = 1'b0;
    cpu_address = 8'h30;
    cpu_writedata = 32'h30303030;
    cpu_write = 1'b1;
    tick();
    cpu_write = 1'b0;
    cpu_read = 1'b1;
    #1;
    check_eq("cpu_rd_wait", 32'(cpu_waitrequest), 32'h1);
    tick();
    check_eq("cpu_rd_done", 32'(cpu_waitrequest), 32'h0);
    check_eq("cpu_wr_rd_30", cpu_readdata, 32'h30303030);
    cpu_read = 1'b0;
    tick();
    jtag_read_at(8'hC4, rd);
`ifdef OCIMEM_ROM_PROTECT_EN
    check_eq("rom_c4", rd, 32'h0C0C0C0C);
`else
    check_eq("rom_c4", rd, 32'hAAAA5555);
`endif

    // a and no_action together: a wins (read at 0x40), error set
    strobe_a(1'b1, 1'b0, 8'h40);
    jdo = '0;
    jdo[34] = 1'b1;
    take_action_ocimem_a = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    tick();
    check_eq("multi_a_read", MonDReg, 32'h44444444);
    check_eq("multi_an_err", 32'(monitor_error), 32'h1);
    tick();

    // Reset during WR at 0x41 aborts the write
    strobe_b(32'h99999999);
    reset = 1'b1;
    tick();
    check_eq("rstwr_mondreg", MonDReg, 32'h0);
    check_eq("rstwr_ready", 32'(monitor_ready), 32'h0);
    check_eq("rstwr_error", 32'(monitor_error), 32'h0);
    check_eq("rstwr_cpu_rdata", cpu_readdata, 32'h0);
    check_eq("rstwr_waitreq", 32'(cpu_waitrequest), 32'h0);
    reset = 1'b0;
    tick();
    jtag_read_at(8'h41, rd);
    check_eq("rstwr_ram", rd, 32'h45454545);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nios_system2_processor1_cpu_debug_ocimem.md
NIOS_SYSTEM2_PROCESSOR1_CPU_DEBUG_OCIMEM -- requirements
Module: nios_system2_processor1_cpu_debug_ocimem

Interface
REQ-001 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-002 reset  in  1  reset, synchronous, active-high.
REQ-003 jdo  in  38  JTAG data from the debug-slave sysclk stage, stable while any strobe is high.
REQ-004 take_action_ocimem_a  in  1  1-cycle strobe: command A (address load and/or read).
REQ-005 take_no_action_ocimem_a  in  1  1-cycle strobe: read next word at current address, no address load.
REQ-006 take_action_ocimem_b  in  1  1-cycle strobe: write jdo[34:3] at current address.
REQ-007 MonDReg  out  32  monitor data register, returned to the debug-slave stage.
REQ-008 monitor_ready  out  1  last JTAG operation complete, MonDReg valid.
REQ-009 monitor_error  out  1  sticky overrun flag.
REQ-010 cpu_address  in  8  CPU word address into debug RAM.
REQ-011 cpu_read, cpu_write  in  1 each  CPU requests, held until accepted.
REQ-012 cpu_writedata  in  32 / cpu_readdata  out  32  CPU data.
REQ-013 cpu_waitrequest  out  1  high while a CPU request is not yet accepted.

Function
REQ-014 Address register MonAReg SHALL be 8 bits (256-word RAM) and SHALL wrap 0xFF -> 0x00 on increment.
REQ-015 take_action_ocimem_a: jdo[35]=1 SHALL load MonAReg <= jdo[33:26]; jdo[34]=1 SHALL start a read (at the newly loaded address if both are set).
REQ-016 take_no_action_ocimem_a SHALL start a read at MonAReg.
REQ-017 Read: with strobe at cycle N, MonDReg SHALL hold RAM[MonAReg] and monitor_ready SHALL be 1 from cycle N+2; MonAReg SHALL increment at N+2.
REQ-018 take_action_ocimem_b SHALL write RAM[MonAReg] <= jdo[34:3] and MonDReg <= jdo[34:3] at N+1; monitor_ready=1 and MonAReg incremented from N+2.
REQ-019 Any JTAG strobe SHALL clear monitor_ready at N+1.
REQ-020 FSM states: IDLE, RD_ADDR, RD_DATA, WR; IDLE->RD_ADDR on read strobe, RD_ADDR->RD_DATA->IDLE; IDLE->WR on write strobe, WR->IDLE.
REQ-021 A strobe received outside IDLE SHALL be ignored and SHALL set monitor_error; an address load (jdo[35]=1) accepted in IDLE SHALL clear it.
REQ-022 More than one strobe high in the same cycle: priority b > a > no_action; monitor_error SHALL be set.
REQ-023 CPU access SHALL be granted only in IDLE with no JTAG strobe that cycle; JTAG SHALL win simultaneous requests.
REQ-024 CPU read: cpu_readdata valid and cpu_waitrequest low in the cycle after grant; CPU write completes (waitrequest low) in the grant cycle.
REQ-025 cpu_waitrequest SHALL be 0 when no CPU request is pending.

Reset
REQ-026 On reset: MonDReg=0, MonAReg=0, monitor_ready=0, monitor_error=0, cpu_readdata=0, FSM=IDLE, cpu_waitrequest=0.
REQ-027 Reset during an operation SHALL abort it; no RAM write SHALL occur in a cycle with reset high; RAM contents are not reset.

Configuration
REQ-028 Macro OCIMEM_ROM_PROTECT_EN defined: addresses 0xC0-0xFF SHALL be read-only from the CPU port (write accepted, RAM unchanged); JTAG writes SHALL be unaffected.
REQ-029 Macro undefined: all 256 words SHALL be CPU-writable.

Structure
REQ-030 Shared package nios_system2_debug_pkg SHALL hold the FSM state enum, RAM depth/address width, jdo field positions (35, 34, 33:26, 34:3) and the protected-region base 0xC0.
REQ-031 One sub-module nios_system2_processor1_cpu_debug_ram: 256x32 single-port synchronous RAM, 1-cycle read latency.

Verification
REQ-032 a-strobe, jdo[35]=1, jdo[34]=1, jdo[33:26]=0x10, RAM[0x10]=0xDEADBEEF -> MonDReg=0xDEADBEEF, monitor_ready at N+2, MonAReg=0x11.
REQ-033 MonAReg=0xFF, b-strobe with jdo[34:3]=0x12345678 -> RAM[0xFF]=0x12345678, MonAReg=0x00, monitor_ready=1.
REQ-034 Second strobe one cycle after a read strobe -> ignored, monitor_error=1; next address load -> monitor_error=0.
REQ-035 cpu_read at 0x20 in the same cycle as an a-strobe -> JTAG served first; cpu_waitrequest high until grant; cpu_readdata correct.
REQ-036 With OCIMEM_ROM_PROTECT_EN, CPU write 0xAAAA5555 to 0xC4 -> RAM[0xC4] unchanged; without the macro -> RAM[0xC4]=0xAAAA5555.
REQ-037 Reset asserted during WR -> RAM unchanged, all outputs at reset values next cycle.
